wb_stage_pipelined: RTL and testbench

//  Parametrised MIPS write-back stage with its own MEM/WB pipeline register; replaces the combinational WB mux.

---
 rtl/mips_pkg.sv | 18 +
 rtl/wb_load_align.sv | 62 ++++++
 rtl/wb_stage_pipelined.sv | 133 +++++++++++++
 tb/tb_wb_stage_pipelined.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS write-back stage: result-select and load-mode codes.
package mips_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_LINK = 2'b10
  } wb_sel_e;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_H  = 3'd1,
    LD_HU = 3'd2,
    LD_B  = 3'd3,
    LD_BU = 3'd4
  } ld_mode_e;

endpackage

// File: rtl/wb_load_align.sv
// Combinational big-endian sub-word extractor: picks the addressed byte/halfword
// out of a raw memory word and sign- or zero-extends it to the datapath width.
module wb_load_align
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] raw_i,
  input  logic [1:0]        offset_i,
  input  logic [2:0]        ld_mode_i,
  output logic [DATA_W-1:0] value_o
);

  function automatic logic [DATA_W-1:0] extend8(input logic [7:0] b, input logic sgn);
    logic signed [7:0] sb;
    sb = $signed(b);
    return sgn ? DATA_W'(sb) : {{(DATA_W-8){1'b0}}, b};
  endfunction

  function automatic logic [DATA_W-1:0] extend16(input logic [15:0] h, input logic sgn);
    logic signed [15:0] sh;
    sh = $signed(h);
    return sgn ? DATA_W'(sh) : {{(DATA_W-16){1'b0}}, h};
  endfunction

  // Byte lanes are defined on the low 32 bits of the raw word.
  logic [31:0] word;
  generate
    if (DATA_W >= 32) begin : g_wide
      assign word = raw_i[31:0];
    end else begin : g_narrow
      assign word = {{(32-DATA_W){1'b0}}, raw_i};
    end
  endgenerate

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[31:24];
    unique case (offset_i)
      2'd0: byte_sel = word[31:24];
      2'd1: byte_sel = word[23:16];
      2'd2: byte_sel = word[15:8];
      2'd3: byte_sel = word[7:0];
      default: byte_sel = word[31:24];
    endcase
    half_sel = offset_i[1] ? word[15:0] : word[31:16];
  end

  always_comb begin
    value_o = raw_i;
    case (ld_mode_i)
      LD_H:    value_o = extend16(half_sel, 1'b1);
      LD_HU:   value_o = extend16(half_sel, 1'b0);
      LD_B:    value_o = extend8(byte_sel, 1'b1);
      LD_BU:   value_o = extend8(byte_sel, 1'b0);
      default: value_o = raw_i;
    endcase
  end

endmodule

// File: rtl/wb_stage_pipelined.sv
// MIPS write-back stage with its own MEM/WB register: result select, load alignment,
// $0 write suppression, forwarding tap and retired-instruction counter.
module wb_stage_pipelined
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_alu_out,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic [DATA_W-1:0] mem_link_pc,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_reg_we,
  input  logic [1:0]        mem_wb_sel,
  input  logic [2:0]        mem_ld_mode,
  input  logic              wb_stall,
  input  logic              wb_flush,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retire_cnt
);

  logic              valid_q,   valid_d;
  logic              counted_q, counted_d;
  logic [DATA_W-1:0] alu_q,     alu_d;
  logic [DATA_W-1:0] rd_q,      rd_d;
  logic [DATA_W-1:0] link_q,    link_d;
  logic [REG_AW-1:0] dest_q,    dest_d;
  logic              we_q,      we_d;
  logic [1:0]        sel_q,     sel_d;
  logic [2:0]        mode_q,    mode_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;

  // Counting happens at capture, so the count is already up when the write shows;
  // the counted flag keeps a held (stalled) instruction from being counted again.
  always_comb begin
    valid_d   = valid_q;
    counted_d = counted_q;
    alu_d     = alu_q;
    rd_d      = rd_q;
    link_d    = link_q;
    dest_d    = dest_q;
    we_d      = we_q;
    sel_d     = sel_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    if (wb_flush) begin
      valid_d   = 1'b0;
      counted_d = 1'b0;
    end else if (wb_stall) begin
      if (valid_q && !counted_q) begin
        counted_d = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
      end
    end else begin
      valid_d   = mem_valid;
      counted_d = mem_valid;
      alu_d     = mem_alu_out;
      rd_d      = mem_rd_data;
      link_d    = mem_link_pc;
      dest_d    = mem_dest;
      we_d      = mem_reg_we;
      sel_d     = mem_wb_sel;
      mode_d    = mem_ld_mode;
      if (mem_valid) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      counted_q <= 1'b0;
      alu_q     <= '0;
      rd_q      <= '0;
      link_q    <= '0;
      dest_q    <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      mode_q    <= '0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      counted_q <= counted_d;
      alu_q     <= alu_d;
      rd_q      <= rd_d;
      link_q    <= link_d;
      dest_q    <= dest_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
    end
  end

  logic [DATA_W-1:0] load_val;

  wb_load_align #(.DATA_W(DATA_W)) u_align (
    .raw_i     (rd_q),
    .offset_i  (alu_q[1:0]),
    .ld_mode_i (mode_q),
    .value_o   (load_val)
  );

  logic [DATA_W-1:0] wdata;
  logic              we_gated;

  always_comb begin
    wdata = alu_q;
    case (sel_q)
      WB_MEM:  wdata = load_val;
      WB_LINK: wdata = link_q;
      default: wdata = alu_q;
    endcase
    we_gated = valid_q && we_q && (dest_q != '0);
  end

  assign rf_we      = we_gated;
  assign rf_waddr   = dest_q;
  assign rf_wdata   = wdata;
  assign fwd_valid  = we_gated;
  assign fwd_addr   = dest_q;
  assign fwd_data   = wdata;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_stage_pipelined.sv
// Directed bench for wb_stage_pipelined (4-bit retire counter to exercise wrap).
module tb_wb_stage_pipelined;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_alu_out;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] mem_link_pc;
  logic [REG_AW-1:0] mem_dest;
  logic              mem_reg_we;
  logic [1:0]        mem_wb_sel;
  logic [2:0]        mem_ld_mode;
  logic              wb_stall;
  logic              wb_flush;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_data;
  logic [CNT_W-1:0]  retire_cnt;

  int n_total;
  int n_pass;
  logic [CNT_W-1:0] exp_cnt;

  wb_stage_pipelined #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_valid   (mem_valid),
    .mem_alu_out (mem_alu_out),
    .mem_rd_data (mem_rd_data),
    .mem_link_pc (mem_link_pc),
    .mem_dest    (mem_dest),
    .mem_reg_we  (mem_reg_we),
    .mem_wb_sel  (mem_wb_sel),
    .mem_ld_mode (mem_ld_mode),
    .wb_stall    (wb_stall),
    .wb_flush    (wb_flush),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .fwd_valid   (fwd_valid),
    .fwd_addr    (fwd_addr),
    .fwd_data    (fwd_data),
    .retire_cnt  (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rd,
                       input logic [31:0] link, input logic [4:0] dest, input logic we,
                       input logic [1:0] sel, input logic [2:0] mode);
    mem_valid   = v;
    mem_alu_out = alu;
    mem_rd_data = rd;
    mem_link_pc = link;
    mem_dest    = dest;
    mem_reg_we  = we;
    mem_wb_sel  = sel;
    mem_ld_mode = mode;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_chk(input string tag, input logic [31:0] alu, input logic [2:0] mode,
                          input logic [31:0] exp);
    drive(1'b1, alu, 32'h80FF7F01, 32'h0, 5'd9, 1'b1, 2'b01, mode);
    tick();
    exp_cnt = exp_cnt + 1'b1;
    chk(tag, rf_wdata, exp);
    chk({tag, "_cnt"}, 32'(retire_cnt), 32'(exp_cnt));
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    exp_cnt = '0;
    rst_n   = 1'b0;
    wb_stall = 1'b0;
    wb_flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 3'd0);

    #2;
    chk("rst_rf_we",  32'(rf_we), 32'h0);
    chk("rst_fwd_v",  32'(fwd_valid), 32'h0);
    chk("rst_cnt",    32'(retire_cnt), 32'h0);
    chk("rst_wdata",  rf_wdata, 32'h0);
    #10 rst_n = 1'b1;

    // LW to $8
    drive(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 5'd8, 1'b1, 2'b01, 3'd0);
    tick();
    exp_cnt = exp_cnt + 1'b1;
    chk("lw_we",    32'(rf_we), 32'h1);
    chk("lw_waddr", 32'(rf_waddr), 32'd8);
    chk("lw_wdata", rf_wdata, 32'hDEADBEEF);
    chk("lw_fwd_v", 32'(fwd_valid), 32'h1);
    chk("lw_fwd_a", 32'(fwd_addr), 32'd8);
    chk("lw_fwd_d", fwd_data, 32'hDEADBEEF);
    chk("lw_cnt",   32'(retire_cnt), 32'd1);

    // Sub-word loads on 0x80FF7F01
    load_chk("lb_off0",  32'h100, 3'd3, 32'hFFFFFF80);
    load_chk("lbu_off0", 32'h100, 3'd4, 32'h00000080);
    load_chk("lh_off2",  32'h102, 3'd1, 32'h00007F01);
    load_chk("lhu_off0", 32'h100, 3'd2, 32'h000080FF);
    load_chk("lb_off1",  32'h101, 3'd3, 32'hFFFFFFFF);
    load_chk("lb_off2",  32'h102, 3'd3, 32'h0000007F);
    load_chk("lbu_off3", 32'h103, 3'd4, 32'h00000001);
    load_chk("lh_off0",  32'h100, 3'd1, 32'hFFFF80FF);
    load_chk("ld_unk",   32'h101, 3'd7, 32'h80FF7F01);

    // JAL link to $31
    drive(1'b1, 32'h1234, 32'h0, 32'h00400008, 5'd31, 1'b1, 2'b10, 3'd0);
    tick();
    exp_cnt = exp_cnt + 1'b1;
    chk("jal_wdata", rf_wdata, 32'h00400008);
    chk("jal_waddr", 32'(rf_waddr), 32'd31);
    chk("jal_we",    32'(rf_we), 32'h1);

    // Reserved select falls back to ALU result
    drive(1'b1, 32'h0000ABCD, 32'h11111111, 32'h22222222, 5'd4, 1'b1, 2'b11, 3'd0);
    tick();
    exp_cnt = exp_cnt + 1'b1;
    chk("sel11_wdata", rf_wdata, 32'h0000ABCD);

    // Write to $0: suppressed, still retired
    drive(1'b1, 32'h00005678, 32'h0, 32'h0, 5'd0, 1'b1, 2'b00, 3'd0);
    tick();
    exp_cnt = exp_cnt + 1'b1;
    chk("r0_we",    32'(rf_we), 32'h0);
    chk("r0_fwd_v", 32'(fwd_valid), 32'h0);
    chk("r0_wdata", rf_wdata, 32'h00005678);
    chk("r0_cnt",   32'(retire_cnt), 32'(exp_cnt));

    // Non-writing instruction and bubble
    drive(1'b1, 32'h1, 32'h0, 32'h0, 5'd7, 1'b0, 2'b00, 3'd0);
    tick();
    exp_cnt = exp_cnt + 1'b1;
    chk("nowe_we", 32'(rf_we), 32'h0);
    drive(1'b0, 32'h2, 32'h0, 32'h0, 5'd7, 1'b1, 2'b00, 3'd0);
    tick();
    chk("bubble_we",  32'(rf_we), 32'h0);
    chk("bubble_cnt", 32'(retire_cnt), 32'(exp_cnt));

    // Instruction A then stall for 3 cycles with a different instruction waiting
    drive(1'b1, 32'h0000AAAA, 32'h0, 32'h0, 5'd5, 1'b1, 2'b00, 3'd0);
    tick();
    exp_cnt = exp_cnt + 1'b1;
    chk("stA_we", 32'(rf_we), 32'h1);
    drive(1'b1, 32'h00005555, 32'h0, 32'h0, 5'd6, 1'b1, 2'b00, 3'd0);
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_we",    32'(rf_we), 32'h1);
      chk("stall_waddr", 32'(rf_waddr), 32'd5);
      chk("stall_wdata", rf_wdata, 32'h0000AAAA);
      chk("stall_cnt",   32'(retire_cnt), 32'(exp_cnt));
    end
    wb_flush = 1'b1;
    tick();
    chk("stflush_we",  32'(rf_we), 32'h0);
    chk("stflush_fwd", 32'(fwd_valid), 32'h0);
    chk("stflush_cnt", 32'(retire_cnt), 32'(exp_cnt));
    wb_stall = 1'b0;
    wb_flush = 1'b0;
    tick();
    exp_cnt = exp_cnt + 1'b1;
    chk("post_waddr", 32'(rf_waddr), 32'd6);
    chk("post_wdata", rf_wdata, 32'h00005555);
    chk("post_cnt",   32'(retire_cnt), 32'(exp_cnt));

    // Asynchronous reset between clock edges
    #3 rst_n = 1'b0;
    #1;
    chk("arst_we",  32'(rf_we), 32'h0);
    chk("arst_fwd", 32'(fwd_valid), 32'h0);
    chk("arst_cnt", 32'(retire_cnt), 32'h0);
    chk("arst_wd",  rf_wdata, 32'h0);
    exp_cnt = '0;
    #2 rst_n = 1'b1;
    drive(1'b1, 32'h00000042, 32'h0, 32'h0, 5'd3, 1'b1, 2'b00, 3'd0);
    tick();
    chk("rel_cnt", 32'(retire_cnt), 32'd1);
    chk("rel_we",  32'(rf_we), 32'h1);

    // 16 more retires: 4-bit counter wraps to 0, then the 17th-after-reset... gives 1
    for (int i = 0; i < 15; i++) tick();
    chk("wrap16_cnt", 32'(retire_cnt), 32'd0);
    tick();
    chk("wrap17_cnt", 32'(retire_cnt), 32'd1);

    drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 3'd0);
    tick();
    chk("idle_we", 32'(rf_we), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
